mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (1-cycle read latency) between the CPU

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (I) and load/store (D) ports.
// Optional fetch anti-starvation guard enabled by defining STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_f
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e owner_r;
    owner_e owner_nxt_s;
    logic   force_i_s;

    if (((DW % 8) != 0) || (MAX_STARVE < 1)) begin : g_bad_param
        $error("mem_port_arbiter: DW must be a multiple of 8 and MAX_STARVE >= 1");
    end

`ifdef STARVE_GUARD_EN
    localparam int SW = ($clog2(MAX_STARVE + 1) < 2) ? 2 : $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);

    logic [SW-1:0] starve_cnt_r;

    // Count consecutive cycles a pending fetch is refused, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (i_req && !i_gnt) begin
            if (starve_cnt_r != STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {SW{1'b0}};
        end
    end

    assign force_i_s = i_req && (starve_cnt_r == STARVE_LIM);
`else
    assign force_i_s = 1'b0;
`endif

    // Pick the winner: D first (older instruction) unless the fetch is overdue
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst_n) begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end else if (d_req && !force_i_s) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    // Steer the RAM strobe/address/byte lanes from whichever port won
    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_wdata = d_wdata;
        mem_addr  = i_addr;
        mem_be    = {BW{1'b0}};
        if (d_gnt) begin
            mem_addr = d_addr;
            mem_be   = d_be;
        end else if (i_gnt) begin
            mem_be   = {BW{1'b1}};
        end else begin
            mem_be   = {BW{1'b0}};
        end
    end

    assign stall_f = rst_n & i_req & ~i_gnt;

    // Remember who owns the read data returning next cycle; stores return nothing
    always_comb begin
        owner_nxt_s = OWN_NONE;
        if (d_gnt && !d_we) begin
            owner_nxt_s = OWN_D;
        end else if (i_gnt) begin
            owner_nxt_s = OWN_I;
        end else begin
            owner_nxt_s = OWN_NONE;
        end
    end

    // Owner register; async reset drops any read still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_nxt_s;
        end
    end

    assign i_rvalid = (owner_r == OWN_I);
    assign d_rvalid = (owner_r == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter with a RAM and a
// rule-level reference model (priority, starvation run length, golden memory).
module tb_mem_port_arbiter;

    localparam int AW         = 12;
    localparam int DW         = 32;
    localparam int MAX_STARVE = 3;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [11:0]   i_addr = 12'h000;
    logic          i_gnt, i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [11:0]   d_addr = 12'h000;
    logic [31:0]   d_wdata = 32'h0;
    logic [3:0]    d_be = 4'h0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en, mem_we;
    logic [11:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata = 32'h0;
    logic          stall_f;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram  [0:4095];
    logic [31:0] gold [0:4095];
    bit          pend_i, pend_d;
    logic [31:0] pend_data;
    int          denied;
    bit          last_ei, last_ed;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .stall_f(stall_f)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency, byte-lane writes
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, check against the model mid-cycle, then advance the model
    task automatic step(input bit ir, input logic [11:0] ia, input bit dr, input bit dwe,
                        input logic [11:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
        bit ei, ed;
        logic [31:0] rd_exp;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
        #3;
        ed = dr && !(GUARD && ir && (denied >= MAX_STARVE));
        ei = ir && !ed;
        check_val("i_gnt",    32'(i_gnt),    32'(ei));
        check_val("d_gnt",    32'(d_gnt),    32'(ed));
        check_val("stall_f",  32'(stall_f),  32'(ir && !ei));
        check_val("mem_en",   32'(mem_en),   32'(ei || ed));
        if (ei || ed) begin
            check_val("mem_we",   32'(mem_we),   32'(ed && dwe));
            check_val("mem_addr", 32'(mem_addr), 32'(ed ? da : ia));
            check_val("mem_be",   32'(mem_be),   32'(ed ? dbe : 4'hF));
            if (ed && dwe) check_val("mem_wdata", mem_wdata, dwd);
        end
        check_val("i_rvalid", 32'(i_rvalid), 32'(pend_i));
        check_val("d_rvalid", 32'(d_rvalid), 32'(pend_d));
        if (pend_i) check_val("i_rdata", i_rdata, pend_data);
        if (pend_d) check_val("d_rdata", d_rdata, pend_data);
        rd_exp = gold[ed ? da : ia];
        @(posedge clk);
        if (ed && dwe)
            for (int b = 0; b < 4; b++)
                if (dbe[b]) gold[da][b*8 +: 8] = dwd[b*8 +: 8];
        pend_i    = ei;
        pend_d    = ed && !dwe;
        pend_data = rd_exp;
        denied    = (ir && !ei) ? ((denied < MAX_STARVE) ? denied + 1 : MAX_STARVE) : 0;
        last_ei   = ei;
        last_ed   = ed;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_gnt"},   32'({i_gnt, d_gnt}),       32'(0));
        check_val({tag, "_rv"},    32'({i_rvalid, d_rvalid}), 32'(0));
        check_val({tag, "_mem"},   32'({mem_en, mem_we, mem_be}), 32'(0));
        check_val({tag, "_stall"}, 32'(stall_f),              32'(0));
    endtask

    bit          ir, dr, dwe;
    logic [11:0] ia, da;
    logic [31:0] dwd;
    logic [3:0]  dbe;

    initial begin
        for (int a = 0; a < 4096; a++) begin
            ram[a]  = 32'h0;
            gold[a] = 32'h0;
        end
        pend_i = 1'b0; pend_d = 1'b0; pend_data = 32'h0; denied = 0;
        i_req = 1'b1; d_req = 1'b1;
        #3;
        check_quiet("rst");
        repeat (2) @(posedge clk);
        #1;
        i_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;

        // Single fetch, then its data returns
        step(1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        check_val("t1_ivalid", 32'(i_rvalid), 32'(1));
        idle();

        // D beats I; I wins once D drops
        step(1'b1, 12'h008, 1'b1, 1'b0, 12'h100, 32'h0, 4'hF);
        step(1'b1, 12'h008, 1'b0, 1'b0, 12'h100, 32'h0, 4'hF);
        idle();

        // Partial store then load back
        step(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 4'b0011);
        idle();
        step(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        check_val("t3_beef", d_rdata, 32'h0000BEEF);
        idle();

        // Fill five words, then fetch them back-to-back
        for (int k = 0; k < 5; k++)
            step(1'b0, 12'h000, 1'b1, 1'b1, 12'(32 + k), $urandom, 4'hF);
        for (int k = 0; k < 5; k++)
            step(1'b1, 12'(32 + k), 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        idle();

        // Both ports held: strict priority or guarded fetch
        for (int k = 0; k < 6; k++)
            step(1'b1, 12'h020, 1'b1, 1'b0, 12'h021, 32'h0, 4'hF);
        idle();

        // Reset asserted while a fetch is being granted
        i_req = 1'b1; i_addr = 12'h030; d_req = 1'b0;
        #2;
        check_val("t5_pre_gnt", 32'(i_gnt), 32'(1));
        rst_n = 1'b0;
        #1;
        check_quiet("t5_in_rst");
        pend_i = 1'b0; pend_d = 1'b0; denied = 0;
        @(posedge clk);
        #1;
        check_quiet("t5_rst_edge");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 12'h030, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        idle();

        // Random traffic; pending requests are usually held until granted
        ir = 1'b0; dr = 1'b0; dwe = 1'b0; ia = 12'h0; da = 12'h0; dwd = 32'h0; dbe = 4'h0;
        last_ei = 1'b0; last_ed = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!(ir && !last_ei && ($urandom_range(0, 7) != 0))) begin
                ir = ($urandom_range(0, 2) != 0);
                ia = 12'($urandom_range(0, 31));
            end
            if (!(dr && !last_ed && ($urandom_range(0, 7) != 0))) begin
                dr  = ($urandom_range(0, 1) != 0);
                dwe = ($urandom_range(0, 1) != 0);
                da  = 12'($urandom_range(0, 31));
                dwd = $urandom;
                dbe = 4'($urandom_range(0, 15));
            end
            step(ir, ia, dr, dwe, da, dwd, dbe);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
